// File: rtl/sysid_reader.sv
// sysid_reader: reads the ID word and then the build timestamp word from an
// Avalon-MM sysid slave, compares each against the expected values and
// reports the outcome through sticky result flags and a one-cycle done pulse.
// A per-transaction cycle counter aborts the sequence when the slave hangs.
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID        = 32'h04000000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h544FD5CA,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state, state_nxt;
    logic [15:0] tmo_cnt;
    logic        in_req, in_wait, tmo_hit, accept, capture;
    logic        id_phase, ts_phase;

    // Decode the current state into Avalon outputs and transaction events.
    // The request is dropped in the cycle the limit is reached so the slave
    // can never accept a read that the FSM is about to abandon.
    always_comb begin
        in_req      = (state == REQ_ID) || (state == REQ_TS);
        in_wait     = (state == WAIT_ID) || (state == WAIT_TS);
        id_phase    = (state == REQ_ID) || (state == WAIT_ID);
        ts_phase    = (state == REQ_TS) || (state == WAIT_TS);
        tmo_hit     = (in_req || in_wait) && (tmo_cnt == TMO_LIMIT);
        avm_read    = in_req && !tmo_hit;
        avm_address = ts_phase;
        accept      = avm_read && !avm_waitrequest;
        // Data counts only once the request is accepted (same cycle or later).
        capture     = !tmo_hit && avm_readdatavalid && (in_wait || accept);
        busy        = (state != IDLE);
        done        = (state == FINISH);
    end

    // Next-state selection; timeout takes priority over late data.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ_ID;
            REQ_ID:  if (tmo_hit)      state_nxt = FINISH;
                     else if (capture) state_nxt = REQ_TS;
                     else if (accept)  state_nxt = WAIT_ID;
            WAIT_ID: if (tmo_hit)      state_nxt = FINISH;
                     else if (capture) state_nxt = REQ_TS;
            REQ_TS:  if (tmo_hit)      state_nxt = FINISH;
                     else if (capture) state_nxt = FINISH;
                     else if (accept)  state_nxt = WAIT_TS;
            WAIT_TS: if (tmo_hit || capture) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Transaction timer: restarts on entry to each request state, counts
    // while a transaction is open and holds at zero otherwise.
    always_ff @(posedge clock) begin
        if (reset)
            tmo_cnt <= '0;
        else if ((state_nxt == REQ_ID && state != REQ_ID) ||
                 (state_nxt == REQ_TS && state != REQ_TS))
            tmo_cnt <= '0;
        else if ((in_req || in_wait) && !tmo_hit)
            tmo_cnt <= tmo_cnt + 16'd1;
        else
            tmo_cnt <= '0;
    end

    // Result capture: cleared by an accepted start, then updated as each
    // word arrives; held unchanged from FINISH until the next start.
    always_ff @(posedge clock) begin
        if (reset || (state == IDLE && start)) begin
            id_value    <= '0;
            ts_value    <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (tmo_hit)
                timeout_err <= 1'b1;
            if (capture && id_phase) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (capture && ts_phase) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            end
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Randomized bench for sysid_reader: a cycle-level Avalon slave with
// programmable stall and latency per word, and an arithmetic model of when
// done must appear and what each result output must hold.
module tb_sysid_reader;

    localparam int          T   = 8;
    localparam logic [31:0] EID = 32'h04000000;
    localparam logic [31:0] ETS = 32'h544FD5CA;

    logic        clock = 1'b0;
    logic        reset, start;
    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata, id_value, ts_value;
    logic        busy, done, id_ok, ts_ok, timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sysid_reader #(
        .EXPECTED_ID       (EID),
        .EXPECTED_TIMESTAMP(ETS),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout_err      (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err}
               | id_value | ts_value;
    endfunction

    // One check sequence. wN = waitrequest cycles, lN = cycles from accept to
    // readdatavalid (0 = same cycle), dN = returned word. abort resets the DUT
    // in WAIT_TS; spam pulses start while busy and injects stray readdatavalid.
    task automatic run_seq(input int w0, input int l0, input int w1, input int l1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit abort, input bit spam);
        int w[2], l[2], reads[2];
        logic [31:0] d[2], resp_d;
        int wcnt, resp_in, dones, done_cyc, unstable, cyc, a, exp_t;
        bit prev_stall, prev_addr, ok0, ok1, fin;
        w[0] = w0; w[1] = w1; l[0] = l0; l[1] = l1; d[0] = d0; d[1] = d1;
        reads[0] = 0; reads[1] = 0;
        wcnt = 0; resp_in = -1; resp_d = '0; dones = 0; done_cyc = -1; unstable = 0;
        prev_stall = 0; prev_addr = 0; fin = 0;
        // Reference: a word succeeds if its stall plus latency fits in T cycles;
        // otherwise the transaction burns T+1 cycles before FINISH.
        ok0   = (w0 + l0 < T);
        ok1   = ok0 && (w1 + l1 < T);
        exp_t = 1 + (ok0 ? w0 + l0 + 1 : T + 1) + (ok0 ? (ok1 ? w1 + l1 + 1 : T + 1) : 0);

        start = 1'b1; avm_waitrequest = 1'b0;
        avm_readdatavalid = spam; avm_readdata = $urandom;
        cyc = 0;
        while (!fin && cyc < 60) begin
            @(posedge clock); #1;
            cyc++;
            start = 1'b0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
            avm_readdata = $urandom;
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk("busy_in_finish", 32'(busy), 32'd1);
            end
            if (prev_stall && (avm_read !== 1'b1 || avm_address !== prev_addr)) unstable++;
            prev_stall = 0;
            if (abort && !avm_read && avm_address && busy && !done) begin
                reset = 1'b1;
                @(posedge clock); #1;
                chk("reset_mid_seq", all_outs(), 32'd0);
                reset = 1'b0;
                repeat (4) begin
                    avm_readdatavalid = 1'b1;
                    @(posedge clock); #1;
                    if (done) dones++;
                end
                avm_readdatavalid = 1'b0;
                chk("abort_no_done", dones, 0);
                chk("abort_idle", 32'(busy), 32'd0);
                return;
            end
            if (resp_in > 0) begin
                resp_in--;
                if (resp_in == 0) begin
                    avm_readdatavalid = 1'b1; avm_readdata = resp_d; resp_in = -1;
                end
            end
            if (avm_read) begin
                a = int'(avm_address);
                if (wcnt < w[a]) begin
                    wcnt++;
                    avm_waitrequest = 1'b1;
                    prev_stall = 1; prev_addr = avm_address;
                    if (spam) avm_readdatavalid = 1'($urandom % 2);
                end else begin
                    wcnt = 0;
                    reads[a]++;
                    if (l[a] == 0) begin
                        avm_readdatavalid = 1'b1; avm_readdata = d[a];
                    end else begin
                        resp_in = l[a]; resp_d = d[a];
                    end
                end
            end
            if (done && spam) avm_readdatavalid = 1'b1;
            if (!busy && done_cyc > 0) begin
                fin = 1;
                chk("done_count", dones, 1);
                chk("done_cycle", done_cyc, exp_t);
                chk("reads_id", reads[0], 32'(w0 < T));
                chk("reads_ts", reads[1], 32'(ok0 && (w1 < T)));
                chk("id_value", id_value, ok0 ? d0 : 32'd0);
                chk("ts_value", ts_value, ok1 ? d1 : 32'd0);
                chk("id_ok", 32'(id_ok), 32'(ok0 && d0 == EID));
                chk("ts_ok", 32'(ts_ok), 32'(ok1 && d1 == ETS));
                chk("timeout_err", 32'(timeout_err), 32'(!ok1));
                chk("read_low_idle", 32'(avm_read), 32'd0);
                if (ok1) chk("req_stable", unstable, 0);
            end
            if (busy && spam) start = 1'($urandom % 2);
        end
        if (!fin) begin
            chk("seq_finished", 32'd0, 32'd1);
            return;
        end
        // Stray data while idle must not disturb the held results.
        repeat (2) begin
            avm_readdatavalid = 1'b1; avm_readdata = $urandom;
            @(posedge clock); #1;
            if (done) dones++;
        end
        avm_readdatavalid = 1'b0;
        chk("hold_id", id_value, ok0 ? d0 : 32'd0);
        chk("hold_ts", ts_value, ok1 ? d1 : 32'd0);
        chk("hold_done", dones, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs", all_outs(), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_outs", all_outs(), 32'd0);

        run_seq(0, 1, 0, 1, EID, ETS, 0, 0);             // zero-wait, matching words
        run_seq(0, 1, 0, 1, 32'h04000001, ETS, 0, 1);    // wrong ID, start spam
        run_seq(3, 1, 3, 1, EID, ETS, 0, 0);             // 3-cycle stall per read
        run_seq(0, 100, 0, 1, EID, ETS, 0, 0);           // ID never returns
        run_seq(1, 2, 0, 3, EID, ETS, 1, 0);             // reset in WAIT_TS
        run_seq(0, 1, 0, 1, EID, ETS, 0, 1);             // normal after abort
        run_seq(4, 3, 7, 0, EID, 32'h544FD5CB, 0, 0);    // exactly T cycles each
        run_seq(5, 3, 0, 1, EID, ETS, 0, 0);             // one cycle over on ID
        run_seq(0, 0, 8, 0, EID, ETS, 0, 1);             // TS stalled past limit
        run_seq(0, 0, 0, 0, EID, ETS, 0, 1);             // same-cycle data both words

        for (int i = 0; i < 40; i++) begin
            logic [31:0] d0, d1;
            d0 = ($urandom % 2) ? EID : (EID ^ (32'd1 << ($urandom % 32)));
            d1 = ($urandom % 2) ? ETS : $urandom;
            run_seq($urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 5), $urandom_range(0, 5),
                    d0, d1, 0, 1'($urandom % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
